cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_if.sv | 31 +++
 rtl/cdb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cdb_if.sv
// Result-offer and broadcast signals between the two producers and the CDB arbiter.
interface cdb_if #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned ROB_SIZE_WIDTH = 4
);
   logic                      alu_ready;
   logic [XLEN-1:0]           alu_res;
   logic [ROB_SIZE_WIDTH-1:0] alu_id;
   logic                      mem_data_ready;
   logic [XLEN-1:0]           mem_data;
   logic [ROB_SIZE_WIDTH-1:0] mem_id;
   logic                      cdb_valid;
   logic [XLEN-1:0]           cdb_val;
   logic [ROB_SIZE_WIDTH-1:0] cdb_id;
   logic                      cdb_src;
   logic                      alu_full;
   logic                      mem_full;
   logic                      overflow;

   // Producer side: offers results, observes broadcast and back-pressure.
   modport master (
      output alu_ready, alu_res, alu_id, mem_data_ready, mem_data, mem_id,
      input  cdb_valid, cdb_val, cdb_id, cdb_src, alu_full, mem_full, overflow
   );

   // Arbiter side.
   modport slave (
      input  alu_ready, alu_res, alu_id, mem_data_ready, mem_data, mem_id,
      output cdb_valid, cdb_val, cdb_id, cdb_src, alu_full, mem_full, overflow
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two result sources (ALU, MEM), each with a small
// holding FIFO and same-cycle bypass, round-robin granted onto one registered
// broadcast per cycle.
module cdb_arbiter #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned ROB_SIZE_WIDTH = 4,
   parameter int unsigned DEPTH          = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   cdb_if.slave bus
);
   localparam int unsigned NSRC  = 2;
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [XLEN-1:0]           val;
      logic [ROB_SIZE_WIDTH-1:0] id;
   } entry_t;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_e;

   // Storage (not reset) and registered state
   entry_t           fifo_q   [NSRC][DEPTH];
   logic [PTR_W-1:0] rd_ptr_q [NSRC];
   logic [PTR_W-1:0] wr_ptr_q [NSRC];
   logic [CNT_W-1:0] cnt_q    [NSRC];
   src_e             last_q;
   logic             ovf_q;
   logic             cdb_valid_q;
   entry_t           cdb_e_q;
   src_e             cdb_src_q;

   // Next-state values
   logic [PTR_W-1:0] rd_ptr_d [NSRC];
   logic [PTR_W-1:0] wr_ptr_d [NSRC];
   logic [CNT_W-1:0] cnt_d    [NSRC];
   src_e             last_d;
   logic             ovf_d;
   logic             cdb_valid_d;
   entry_t           cdb_e_d;
   src_e             cdb_src_d;

   // Per-source decode
   entry_t           offer_e  [NSRC];
   entry_t           cand_e   [NSRC];
   logic [NSRC-1:0]  offer_v;
   logic [NSRC-1:0]  nonempty;
   logic [NSRC-1:0]  full;
   logic [NSRC-1:0]  cand_v;
   logic [NSRC-1:0]  gnt;
   logic [NSRC-1:0]  pop;
   logic [NSRC-1:0]  want_push;
   logic [NSRC-1:0]  drop;
   logic [NSRC-1:0]  push;
   logic             grant;
   src_e             win;

   // Candidate selection, round-robin grant, FIFO control and next state.
   always_comb begin
      offer_v    = {bus.mem_data_ready, bus.alu_ready};
      offer_e[0] = {bus.alu_res, bus.alu_id};
      offer_e[1] = {bus.mem_data, bus.mem_id};

      for (int s = 0; s < NSRC; s++) begin
         nonempty[s] = (cnt_q[s] != '0);
         full[s]     = (cnt_q[s] == CNT_W'(DEPTH));
         cand_v[s]   = nonempty[s] | offer_v[s];
         cand_e[s]   = nonempty[s] ? fifo_q[s][rd_ptr_q[s]] : offer_e[s];
      end

      // Tie goes to the source that did not win last.
      win = SRC_ALU;
      if (&cand_v) begin
         win = (last_q == SRC_ALU) ? SRC_MEM : SRC_ALU;
      end else if (cand_v[1]) begin
         win = SRC_MEM;
      end
      grant  = |cand_v;
      gnt[0] = grant && (win == SRC_ALU);
      gnt[1] = grant && (win == SRC_MEM);

      // A granted bypass offer is never stored; an offer into a full FIFO
      // survives only if the same edge pops that FIFO.
      for (int s = 0; s < NSRC; s++) begin
         pop[s]       = gnt[s] & nonempty[s];
         want_push[s] = offer_v[s] & ~(gnt[s] & ~nonempty[s]);
         drop[s]      = want_push[s] & full[s] & ~pop[s] & ~flush;
         push[s]      = want_push[s] & ~full[s] & ~flush
                      | want_push[s] & pop[s] & ~flush;
      end

      for (int s = 0; s < NSRC; s++) begin
         rd_ptr_d[s] = rd_ptr_q[s];
         wr_ptr_d[s] = wr_ptr_q[s];
         cnt_d[s]    = cnt_q[s];
      end
      last_d      = last_q;
      ovf_d       = ovf_q | (|drop);
      cdb_valid_d = grant;
      cdb_e_d     = cdb_e_q;
      cdb_src_d   = cdb_src_q;

      if (flush) begin
         for (int s = 0; s < NSRC; s++) begin
            rd_ptr_d[s] = '0;
            wr_ptr_d[s] = '0;
            cnt_d[s]    = '0;
         end
         cdb_valid_d = 1'b0;
      end else begin
         for (int s = 0; s < NSRC; s++) begin
            if (pop[s])  rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
            if (push[s]) wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(1);
            case ({push[s], pop[s]})
               2'b10:   cnt_d[s] = cnt_q[s] + CNT_W'(1);
               2'b01:   cnt_d[s] = cnt_q[s] - CNT_W'(1);
               default: cnt_d[s] = cnt_q[s];
            endcase
         end
         if (grant) begin
            last_d    = win;
            cdb_src_d = win;
            cdb_e_d   = (win == SRC_MEM) ? cand_e[1] : cand_e[0];
         end
      end
   end

   // State register with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NSRC; s++) begin
            rd_ptr_q[s] <= '0;
            wr_ptr_q[s] <= '0;
            cnt_q[s]    <= '0;
         end
         last_q      <= SRC_MEM;
         ovf_q       <= 1'b0;
         cdb_valid_q <= 1'b0;
         cdb_e_q     <= '0;
         cdb_src_q   <= SRC_ALU;
      end else begin
         for (int s = 0; s < NSRC; s++) begin
            rd_ptr_q[s] <= rd_ptr_d[s];
            wr_ptr_q[s] <= wr_ptr_d[s];
            cnt_q[s]    <= cnt_d[s];
         end
         last_q      <= last_d;
         ovf_q       <= ovf_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_e_q     <= cdb_e_d;
         cdb_src_q   <= cdb_src_d;
      end
   end

   // FIFO payload storage; written at the tail on push.
   always_ff @(posedge clk) begin
      for (int s = 0; s < NSRC; s++) begin
         if (push[s]) fifo_q[s][wr_ptr_q[s]] <= offer_e[s];
      end
   end

   // Broadcast and status outputs.
   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_val   = cdb_e_q.val;
   assign bus.cdb_id    = cdb_e_q.id;
   assign bus.cdb_src   = cdb_src_q;
   assign bus.overflow  = ovf_q;
   assign bus.alu_full  = full[0];
   assign bus.mem_full  = full[1];
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (XLEN=32, ROB id 4 bits, DEPTH=2).
module tb_cdb_arbiter;
   logic clk;
   logic rst_n;
   logic flush;
   int   n_cmp;
   int   n_bad;

   cdb_if #(.XLEN(32), .ROB_SIZE_WIDTH(4)) bus ();

   cdb_arbiter #(.XLEN(32), .ROB_SIZE_WIDTH(4), .DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus.slave)
   );

   // 10-unit clock, posedges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Run-time bound.
   initial begin
      #50000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic av, input logic [3:0] aid,
                        input logic mv, input logic [3:0] mid);
      bus.alu_ready      = av;
      bus.alu_id         = aid;
      bus.alu_res        = 32'h0A0 + 32'(aid);
      bus.mem_data_ready = mv;
      bus.mem_id         = mid;
      bus.mem_data       = 32'h0B0 + 32'(mid);
   endtask

   task automatic idle();
      offer(1'b0, 4'd0, 1'b0, 4'd0);
   endtask

   // Broadcast check; ALU values are 0xA0+id, MEM values 0xB0+id.
   task automatic exp_b(input string tag, input logic src, input logic [3:0] id);
      chk({tag, ".valid"}, 64'(bus.cdb_valid), 64'd1);
      chk({tag, ".src"},   64'(bus.cdb_src),   64'(src));
      chk({tag, ".id"},    64'(bus.cdb_id),    64'(id));
      chk({tag, ".val"},   64'(bus.cdb_val),   src ? 64'h0B0 + 64'(id) : 64'h0A0 + 64'(id));
   endtask

   task automatic exp_idle(input string tag);
      chk({tag, ".valid"}, 64'(bus.cdb_valid), 64'd0);
   endtask

   task automatic do_reset();
      idle();
      flush = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      flush = 1'b0;
      rst_n = 1'b1;
      idle();

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst.valid", 64'(bus.cdb_valid), 64'd0);
      chk("rst.val",   64'(bus.cdb_val),   64'd0);
      chk("rst.id",    64'(bus.cdb_id),    64'd0);
      chk("rst.src",   64'(bus.cdb_src),   64'd0);
      chk("rst.ovf",   64'(bus.overflow),  64'd0);
      chk("rst.afull", 64'(bus.alu_full),  64'd0);
      chk("rst.mfull", 64'(bus.mem_full),  64'd0);
      #10 rst_n = 1'b1;

      // Single ALU bypass offer, one-cycle latency
      bus.alu_ready = 1'b1; bus.alu_res = 32'h11; bus.alu_id = 4'd3;
      step();
      chk("single.valid", 64'(bus.cdb_valid), 64'd1);
      chk("single.val",   64'(bus.cdb_val),   64'h11);
      chk("single.id",    64'(bus.cdb_id),    64'd3);
      chk("single.src",   64'(bus.cdb_src),   64'd0);
      idle();
      step();
      exp_idle("single.after");

      // Ties after reset: ALU first, then MEM; twice
      do_reset();
      for (int r = 0; r < 2; r++) begin
         offer(1'b1, 4'd1, 1'b1, 4'd2);
         step();
         exp_b("tie.alu", 1'b0, 4'd1);
         chk("tie.mfull0", 64'(bus.mem_full), 64'd0);
         idle();
         step();
         exp_b("tie.mem", 1'b1, 4'd2);
         chk("tie.mfull1", 64'(bus.mem_full), 64'd0);
      end
      step();
      exp_idle("tie.idle");

      // MEM ids 4,5,6 with ALU ids 8,9,10 offered alongside
      offer(1'b1, 4'd8, 1'b1, 4'd4);  step(); exp_b("rr.e0", 1'b0, 4'd8);
      offer(1'b1, 4'd9, 1'b1, 4'd5);  step(); exp_b("rr.e1", 1'b1, 4'd4);
      offer(1'b1, 4'd10, 1'b1, 4'd6); step(); exp_b("rr.e2", 1'b0, 4'd9);
      chk("rr.mfull", 64'(bus.mem_full), 64'd1);
      idle();
      step(); exp_b("rr.e3", 1'b1, 4'd5);
      step(); exp_b("rr.e4", 1'b0, 4'd10);
      step(); exp_b("rr.e5", 1'b1, 4'd6);
      step(); exp_idle("rr.e6");
      chk("rr.ovf", 64'(bus.overflow), 64'd0);

      // Fill ALU FIFO, then drop an offer while MEM wins
      do_reset();
      offer(1'b1, 4'd1, 1'b1, 4'd9);  step(); exp_b("ov.e0", 1'b0, 4'd1);
      offer(1'b1, 4'd2, 1'b0, 4'd0);  step(); exp_b("ov.e1", 1'b1, 4'd9);
      offer(1'b1, 4'd3, 1'b1, 4'd10); step(); exp_b("ov.e2", 1'b0, 4'd2);
      offer(1'b1, 4'd4, 1'b0, 4'd0);  step(); exp_b("ov.e3", 1'b1, 4'd10);
      chk("ov.afull3", 64'(bus.alu_full), 64'd1);
      offer(1'b1, 4'd5, 1'b0, 4'd0);  step(); exp_b("ov.e4", 1'b0, 4'd3);
      chk("ov.afull4", 64'(bus.alu_full), 64'd1);
      chk("ov.ovf4",   64'(bus.overflow), 64'd0);
      offer(1'b1, 4'd6, 1'b1, 4'd11); step(); exp_b("ov.e5", 1'b1, 4'd11);
      chk("ov.ovf5",   64'(bus.overflow), 64'd1);
      idle();
      step(); exp_b("ov.e6", 1'b0, 4'd4);
      step(); exp_b("ov.e7", 1'b0, 4'd5);
      step(); exp_idle("ov.e8");
      chk("ov.sticky", 64'(bus.overflow), 64'd1);

      // Flush with two buffered entries and a bypass offer (last_grant = ALU)
      offer(1'b1, 4'd1, 1'b1, 4'd2); step(); exp_b("fl.a", 1'b1, 4'd2);
      offer(1'b1, 4'd3, 1'b1, 4'd4); step(); exp_b("fl.b", 1'b0, 4'd1);
      offer(1'b1, 4'd5, 1'b0, 4'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle();
      exp_idle("fl.c");
      chk("fl.afull", 64'(bus.alu_full), 64'd0);
      chk("fl.mfull", 64'(bus.mem_full), 64'd0);
      step(); exp_idle("fl.d1");
      step(); exp_idle("fl.d2");
      chk("fl.ovf", 64'(bus.overflow), 64'd1);
      offer(1'b1, 4'd6, 1'b1, 4'd7); step(); exp_b("fl.tie", 1'b1, 4'd7);
      offer(1'b0, 4'd0, 1'b1, 4'd8); step(); exp_b("fl.e", 1'b0, 4'd6);
      idle();

      // Async reset between edges while broadcasting with MEM id 8 buffered
      #1 rst_n = 1'b0;
      #1;
      chk("ar.valid", 64'(bus.cdb_valid), 64'd0);
      chk("ar.val",   64'(bus.cdb_val),   64'd0);
      chk("ar.id",    64'(bus.cdb_id),    64'd0);
      chk("ar.src",   64'(bus.cdb_src),   64'd0);
      chk("ar.ovf",   64'(bus.overflow),  64'd0);
      #1 rst_n = 1'b1;
      step(); exp_idle("ar.discard");
      offer(1'b1, 4'd12, 1'b1, 4'd13); step(); exp_b("ar.tie", 1'b0, 4'd12);
      idle();
      step(); exp_b("ar.mem", 1'b1, 4'd13);
      step(); exp_idle("ar.end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
